// File: rtl/cnt52_pkg.sv
// cnt52_pkg: shared types and helpers for the 5:2 counter frame accumulator
package cnt52_pkg;
  typedef enum logic {ACCUM, DONE} state_t;
  localparam int PAIR_MAX = 3;
  function automatic logic [1:0] pair_val(input logic s, input logic ca);
    return {ca, s};
  endfunction
endpackage

// File: rtl/cnt52_sat_add.sv
// cnt52_sat_add: W-bit plus pair-value adder that clamps to all-ones on overflow
module cnt52_sat_add
  import cnt52_pkg::*;
#(
  parameter int W = 6
) (
  input  logic [W-1:0]                   i_a,
  input  logic [$clog2(PAIR_MAX+1)-1:0] i_b,
  output logic [W-1:0]                   o_sum,
  output logic                           o_ovf
);
  localparam int B_W = $clog2(PAIR_MAX + 1);
  logic [W:0] w_full;
  assign w_full = {1'b0, i_a} + {{(W + 1 - B_W){1'b0}}, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = o_ovf ? '1 : w_full[W-1:0];
endmodule

// File: rtl/cnt52_frame_accum.sv
// cnt52_frame_accum: sums FRAME_LEN {ca,s} pairs into a saturating frame count
module cnt52_frame_accum
  import cnt52_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic             in_ca,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovf_flag;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_ovf;
  logic [ACC_W-1:0] w_sum;
  logic             w_ovf;
  logic             w_last;
  cnt52_sat_add #(.W(ACC_W)) u_add (
    .i_a  (r_acc),
    .i_b  (pair_val(in_s, in_ca)),
    .o_sum(w_sum),
    .o_ovf(w_ovf)
  );
  assign w_last    = (r_idx == IDX_W'(FRAME_LEN - 1));
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  // Frame FSM: accumulate pairs, latch the total on the last one, hold it until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_idx       <= '0;
      r_ovf_flag  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clear) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_idx       <= '0;
      r_ovf_flag  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (in_valid) begin
        if (w_last) begin
          r_out_sum   <= w_sum;
          r_out_ovf   <= r_ovf_flag | w_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_idx       <= '0;
          r_ovf_flag  <= 1'b0;
          r_state     <= DONE;
        end else begin
          r_acc      <= w_sum;
          r_idx      <= r_idx + 1'b1;
          r_ovf_flag <= r_ovf_flag | w_ovf;
        end
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_state     <= ACCUM;
    end
  end
endmodule

// File: tb/tb_cnt52_frame_accum.sv
// tb_cnt52_frame_accum: directed bench, two widths fed identical stimulus against a frame model
module tb_cnt52_frame_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_s = 1'b0;
  logic       in_ca = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready6, out_valid6, out_ovf6;
  logic [5:0] out_sum6;
  logic       in_ready5, out_valid5, out_ovf5;
  logic [4:0] out_sum5;
  int         n_chk = 0;
  int         n_fail = 0;
  bit         started = 1'b0;
  int         m_cnt[2], m_tot[2], m_sum[2];
  bit         m_pend[2], m_ovf[2];

  always #5 clk = ~clk;

  cnt52_frame_accum #(.FRAME_LEN(16), .ACC_W(6)) u6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
    .in_s(in_s), .in_ca(in_ca), .out_valid(out_valid6), .out_ready(out_ready),
    .out_sum(out_sum6), .out_ovf(out_ovf6)
  );
  cnt52_frame_accum #(.FRAME_LEN(16), .ACC_W(5)) u5 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready5),
    .in_s(in_s), .in_ca(in_ca), .out_valid(out_valid5), .out_ready(out_ready),
    .out_sum(out_sum5), .out_ovf(out_ovf5)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: exact running total per frame, clamped once at the frame end
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pend[k] = 1'b0; m_cnt[k] = 0; m_tot[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0;
      end else if (clear) begin
        m_pend[k] = 1'b0; m_cnt[k] = 0; m_tot[k] = 0;
      end else if (m_pend[k]) begin
        if (out_ready) m_pend[k] = 1'b0;
      end else if (in_valid) begin
        m_tot[k] += 2 * int'(in_ca) + int'(in_s);
        m_cnt[k]++;
        if (m_cnt[k] == 16) begin
          m_sum[k]  = (m_tot[k] > (k ? 31 : 63)) ? (k ? 31 : 63) : m_tot[k];
          m_ovf[k]  = m_tot[k] > (k ? 31 : 63);
          m_pend[k] = 1'b1;
          m_cnt[k]  = 0;
          m_tot[k]  = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready6", 32'(in_ready6), 32'(!m_pend[0]));
      chk("out_valid6", 32'(out_valid6), 32'(m_pend[0]));
      chk("in_ready5", 32'(in_ready5), 32'(!m_pend[1]));
      chk("out_valid5", 32'(out_valid5), 32'(m_pend[1]));
      if (m_pend[0]) begin
        chk("out_sum6", 32'(out_sum6), 32'(m_sum[0]));
        chk("out_ovf6", 32'(out_ovf6), 32'(m_ovf[0]));
      end
      if (m_pend[1]) begin
        chk("out_sum5", 32'(out_sum5), 32'(m_sum[1]));
        chk("out_ovf5", 32'(out_ovf5), 32'(m_ovf[1]));
      end
    end
  end

  task automatic cyc(input logic v, input logic ca, input logic s, input logic ordy, input logic clr);
    in_valid = v; in_ca = ca; in_s = s; out_ready = ordy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int s6, input int o6, input int s5, input int o5);
    chk({nm, "_valid6"}, 32'(out_valid6), 32'd1);
    chk({nm, "_sum6"}, 32'(out_sum6), 32'(s6));
    chk({nm, "_ovf6"}, 32'(out_ovf6), 32'(o6));
    chk({nm, "_valid5"}, 32'(out_valid5), 32'd1);
    chk({nm, "_sum5"}, 32'(out_sum5), 32'(s5));
    chk({nm, "_ovf5"}, 32'(out_ovf5), 32'(o5));
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid6", 32'(out_valid6), 32'd0);
    chk("async_rst_valid5", 32'(out_valid5), 32'd0);
    chk("async_rst_ready6", 32'(in_ready6), 32'd1);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid6), 32'd0);
    chk("rst_sum", 32'(out_sum6), 32'd0);
    chk("rst_ovf", 32'(out_ovf6), 32'd0);
    chk("rst_ready", 32'(in_ready6), 32'd1);
    rst_n = 1'b1;
    started = 1'b1;
    // back-to-back all-ones frame; the narrow instance saturates
    for (int i = 0; i < 16; i++) cyc(1, 1, 1, 1, 0);
    pin("t1", 48, 0, 31, 1);
    cyc(0, 0, 0, 1, 0);
    // all-zero frame clears the sticky overflow
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 1, 0);
    pin("t4", 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    // mixed frame then back-pressure on the result
    for (int i = 0; i < 16; i++) cyc(1, i[1], i[0], 0, 0);
    pin("t2", 24, 0, 24, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 1, 0, 0);
      chk("t2_hold_ready", 32'(in_ready6), 32'd0);
      chk("t2_hold_sum", 32'(out_sum6), 32'd24);
    end
    cyc(1, 1, 1, 1, 0);
    chk("t2_release", 32'(out_valid6), 32'd0);
    // input gaps every other cycle
    for (int i = 0; i < 32; i++) begin
      cyc(i % 2 == 0, 1, 1, 1, 0);
      if (i == 30) pin("t3", 48, 0, 31, 1);
    end
    // clear mid-frame drops the partial sum and the pair offered with it
    for (int i = 0; i < 7; i++) cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 0);
    pin("t5", 16, 0, 16, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t5_clear_done", 32'(out_valid6), 32'd0);
    chk("t5_clear_ready", 32'(in_ready6), 32'd1);
    // async reset mid-frame, then while a result is pending
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0);
    rst_pulse();
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 0, 0);
    pin("t6a", 32, 0, 31, 1);
    rst_pulse();
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 1, 0);
    pin("t6b", 16, 0, 16, 0);
    cyc(0, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
